clock_ctrl: RTL and testbench

Mode and timebase controller for the digital clock datapath. Generates the 1 Hz tick from the system clock and sequences the seconds, minutes and hours counters. In RUN it drives the enable/carry chain. In the two set modes it freezes the seconds counter and steers user increment pulses to the hours or minutes counter.

---
 rtl/clock_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_clock_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// clock_ctrl: mode sequencer and 1 Hz timebase for the digital clock datapath.
// RUN drives the seconds/minutes/hours carry chain from the 1 s tick; SET_HR
// and SET_MIN freeze the seconds counter and steer inc_btn pulses to the
// selected field while a 1 Hz blink marks it on the display.
module clock_ctrl #(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       sec_ovf,
  input  logic       min_ovf,
  output logic       sec_en,
  output logic       sec_clr,
  output logic       min_en,
  output logic       hr_en,
  output logic [1:0] mode,
  output logic       blink,
  output logic       tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(TICK_DIV / 2);
  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(TICK_DIV / 2 - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2
  } state_t;

  state_t          state_r;
  logic [PW-1:0]   pre_cnt_r;
  logic [BW-1:0]   blink_cnt_r;
  logic            blink_r;
  logic            tick_r;
  logic            sec_clr_r;
  logic            in_set_s;
  logic            enter_set_s;

  // Decode whether we sit in a set mode and whether this edge enters one.
  always_comb begin
    in_set_s    = 1'b0;
    enter_set_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        in_set_s    = 1'b0;
        enter_set_s = mode_btn;
      end
      ST_SET_HR: begin
        in_set_s    = 1'b1;
        enter_set_s = mode_btn;
      end
      ST_SET_MIN: begin
        in_set_s    = 1'b1;
        enter_set_s = 1'b0;
      end
      default: begin
        in_set_s    = 1'b0;
        enter_set_s = 1'b0;
      end
    endcase
  end

  // Mode FSM with registered tick and seconds-clear pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_RUN;
      tick_r    <= 1'b0;
      sec_clr_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          // A mode press on the wrap edge swallows the pending tick.
          tick_r    <= (pre_cnt_r == PRE_LAST) && !mode_btn;
          sec_clr_r <= mode_btn;
          if (mode_btn) begin
            state_r <= ST_SET_HR;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_SET_HR: begin
          tick_r    <= 1'b0;
          sec_clr_r <= 1'b0;
          if (mode_btn) begin
            state_r <= ST_SET_MIN;
          end else begin
            state_r <= ST_SET_HR;
          end
        end
        ST_SET_MIN: begin
          tick_r    <= 1'b0;
          sec_clr_r <= 1'b0;
          if (mode_btn) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_SET_MIN;
          end
        end
        default: begin
          tick_r    <= 1'b0;
          sec_clr_r <= 1'b0;
          state_r   <= ST_RUN;
        end
      endcase
    end
  end

  // Prescaler: free-runs 0..TICK_DIV-1 in RUN, parked at zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_r <= {PW{1'b0}};
    end else if ((state_r == ST_RUN) && !mode_btn) begin
      if (pre_cnt_r == PRE_LAST) begin
        pre_cnt_r <= {PW{1'b0}};
      end else begin
        pre_cnt_r <= pre_cnt_r + PW'(1);
      end
    end else begin
      pre_cnt_r <= {PW{1'b0}};
    end
  end

  // Blink generator: restarts lit on every set-mode entry, toggles each half period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_r <= {BW{1'b0}};
      blink_r     <= 1'b0;
    end else if (enter_set_s) begin
      blink_cnt_r <= {BW{1'b0}};
      blink_r     <= 1'b1;
    end else if (in_set_s && !mode_btn) begin
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_r <= {BW{1'b0}};
        blink_r     <= ~blink_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BW'(1);
        blink_r     <= blink_r;
      end
    end else begin
      blink_cnt_r <= {BW{1'b0}};
      blink_r     <= 1'b0;
    end
  end

  // Counter enables: carry chain in RUN, user increments in set modes (mode press wins).
  always_comb begin
    sec_en = 1'b0;
    min_en = 1'b0;
    hr_en  = 1'b0;
    case (state_r)
      ST_RUN: begin
        sec_en = tick_r;
        min_en = sec_ovf;
        hr_en  = min_ovf;
      end
      ST_SET_HR: begin
        sec_en = 1'b0;
        min_en = 1'b0;
        hr_en  = inc_btn && !mode_btn;
      end
      ST_SET_MIN: begin
        sec_en = 1'b0;
        min_en = inc_btn && !mode_btn;
        hr_en  = 1'b0;
      end
      default: begin
        sec_en = 1'b0;
        min_en = 1'b0;
        hr_en  = 1'b0;
      end
    endcase
  end

  assign mode    = state_r;
  assign blink   = blink_r;
  assign tick    = tick_r;
  assign sec_clr = sec_clr_r;

endmodule

// File: tb/tb_clock_ctrl.sv
// tb_clock_ctrl: directed-vector bench for clock_ctrl with TICK_DIV=10.
module tb_clock_ctrl;

  logic       clk;
  logic       rst_n;
  logic       mode_btn;
  logic       inc_btn;
  logic       sec_ovf;
  logic       min_ovf;
  logic       sec_en;
  logic       sec_clr;
  logic       min_en;
  logic       hr_en;
  logic [1:0] mode;
  logic       blink;
  logic       tick;

  int n_checks;
  int n_pass;

  clock_ctrl #(.TICK_DIV(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode_btn (mode_btn),
    .inc_btn  (inc_btn),
    .sec_ovf  (sec_ovf),
    .min_ovf  (min_ovf),
    .sec_en   (sec_en),
    .sec_clr  (sec_clr),
    .min_en   (min_en),
    .hr_en    (hr_en),
    .mode     (mode),
    .blink    (blink),
    .tick     (tick)
  );

  // 10 ns system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hard bound on run time.
  initial begin
    #100000;
    $display("FAIL timeout: got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    sec_ovf  = 1'b0;
    min_ovf  = 1'b0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    #7;
    check_eq("rst_mode", mode, 0);
    check_eq("rst_tick", tick, 0);
    check_eq("rst_blink", blink, 0);
    check_eq("rst_sec_clr", sec_clr, 0);

    // Free run: ticks on edges 10, 20, 30.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      step();
      check_eq($sformatf("run_tick_%0d", k), tick, (k % 10 == 0) ? 1 : 0);
      check_eq($sformatf("run_sec_en_%0d", k), sec_en, (k % 10 == 0) ? 1 : 0);
    end
    check_eq("run_mode", mode, 0);
    check_eq("run_blink", blink, 0);

    // Full carry chain on the tick at edge 40.
    for (int k = 36; k <= 39; k++) step();
    check_eq("pre_tick_sec_en", sec_en, 0);
    sec_ovf = 1'b1;
    min_ovf = 1'b1;
    step();
    check_eq("carry_tick", tick, 1);
    check_eq("carry_sec_en", sec_en, 1);
    check_eq("carry_min_en", min_en, 1);
    check_eq("carry_hr_en", hr_en, 1);
    sec_ovf = 1'b0;
    min_ovf = 1'b0;
    #1;
    check_eq("carry_off_min_en", min_en, 0);
    check_eq("carry_off_hr_en", hr_en, 0);

    // inc_btn ignored in RUN.
    inc_btn = 1'b1;
    #1;
    check_eq("run_inc_hr_en", hr_en, 0);
    check_eq("run_inc_min_en", min_en, 0);
    inc_btn = 1'b0;

    // Enter SET_HR.
    mode_btn = 1'b1;
    step();
    mode_btn = 1'b0;
    check_eq("sethr_mode", mode, 1);
    check_eq("sethr_sec_clr", sec_clr, 1);
    check_eq("sethr_blink0", blink, 1);
    check_eq("sethr_tick0", tick, 0);
    for (int j = 1; j <= 12; j++) begin
      step();
      check_eq($sformatf("sethr_sec_clr_%0d", j), sec_clr, 0);
      check_eq($sformatf("sethr_tick_%0d", j), tick, 0);
      check_eq($sformatf("sethr_blink_%0d", j), blink, ((j / 5) % 2 == 0) ? 1 : 0);
    end

    // Three hour increments.
    for (int i = 0; i < 3; i++) begin
      inc_btn = 1'b1;
      #1;
      check_eq($sformatf("inc_hr_en_%0d", i), hr_en, 1);
      check_eq($sformatf("inc_min_en_%0d", i), min_en, 0);
      check_eq($sformatf("inc_sec_en_%0d", i), sec_en, 0);
      step();
      inc_btn = 1'b0;
      #1;
      check_eq($sformatf("inc_hr_off_%0d", i), hr_en, 0);
    end

    // Enter SET_MIN.
    mode_btn = 1'b1;
    step();
    mode_btn = 1'b0;
    check_eq("setmin_mode", mode, 2);
    check_eq("setmin_blink", blink, 1);
    check_eq("setmin_sec_clr", sec_clr, 0);
    inc_btn = 1'b1;
    min_ovf = 1'b1;
    #1;
    check_eq("setmin_min_en", min_en, 1);
    check_eq("setmin_hr_en", hr_en, 0);
    check_eq("setmin_sec_en", sec_en, 0);
    step();
    inc_btn = 1'b0;
    min_ovf = 1'b0;

    // mode_btn and inc_btn together: mode wins, back to RUN.
    mode_btn = 1'b1;
    inc_btn  = 1'b1;
    #1;
    check_eq("both_min_en", min_en, 0);
    check_eq("both_hr_en", hr_en, 0);
    step();
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    check_eq("exit_mode", mode, 0);
    check_eq("exit_blink", blink, 0);
    check_eq("exit_sec_clr", sec_clr, 0);
    for (int j = 1; j <= 10; j++) begin
      step();
      check_eq($sformatf("exit_tick_%0d", j), tick, (j == 10) ? 1 : 0);
    end

    // mode_btn on the prescaler wrap edge suppresses the tick.
    for (int j = 11; j <= 19; j++) step();
    check_eq("wrap_pre_tick", tick, 0);
    mode_btn = 1'b1;
    step();
    mode_btn = 1'b0;
    check_eq("wrap_tick_suppressed", tick, 0);
    check_eq("wrap_mode", mode, 1);
    check_eq("wrap_sec_clr", sec_clr, 1);

    // Into SET_MIN, then asynchronous reset while blink is lit.
    mode_btn = 1'b1;
    step();
    mode_btn = 1'b0;
    check_eq("prerst_mode", mode, 2);
    check_eq("prerst_blink", blink, 1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_mode", mode, 0);
    check_eq("async_rst_blink", blink, 0);
    check_eq("async_rst_tick", tick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      step();
      check_eq($sformatf("post_rst_tick_%0d", j), tick, (j == 10) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
